inference_scheduler: RTL
========================

# inference_scheduler

Front-end sequencer for the layer-multiplexed network. Accepts one input vector at a time over a valid/ready handshake and issues the one-cycle `start` plus held `start_input` to the layer controller. It counts `layer_start` pulses, waits for a network-done pulse or a timeout, and returns the captured final output with status through an output valid/ready handshake. It owns the single shared network instance, so only one inference is in flight at a time.

## Interface
Parameters:
- NUM_NEURON, 6, neurons per layer / vector elements
- INPUT_SIZE, 9, bits per vector element
- LAYER_MAX, 4, expected number of `layer_start` pulses per inference
- TIMEOUT, 1024, max cycles after `start` before abort (≥1, < 2^CNT_SIZE)
- CNT_SIZE, 16, width of cycle counter
- LW = log2(LAYER_MAX)+1, derived width of layer count (ceil-log2 as elsewhere in the design)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input vector available
- in_ready  out  1  scheduler can accept a vector
- in_data  in  NUM_NEURON*INPUT_SIZE  input vector
- start  out  1  one-cycle start to layer controller
- start_input  out  NUM_NEURON*INPUT_SIZE  registered vector, stable from acceptance to next acceptance
- layer_start  in  1  pulse per layer launched by the controller
- final_output  in  NUM_NEURON*INPUT_SIZE  network result, sampled on `net_done`
- net_done  in  1  one-cycle pulse: `final_output` is valid
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  NUM_NEURON*INPUT_SIZE  captured result
- out_layers  out  LW  `layer_start` pulses counted for this inference
- out_cycles  out  CNT_SIZE  cycles from `start` to completion
- err_timeout  out  1  inference aborted by timeout
- err_layers  out  1  completed with `out_layers != LAYER_MAX`
- busy  out  1  state != IDLE

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`: latch `in_data` into `start_input`, go to START.
- START: `start`=1 for exactly this cycle; clear cycle count to 0 and layer count to 0; go to RUN.
- RUN: let k = cycles since the START cycle (first RUN cycle is k=1). Each RUN cycle, `layer_start` increments the layer count, saturating at 2^LW-1.
- RUN, `net_done` sampled at cycle k: capture `final_output` into `out_data`, `out_cycles`=k. `out_layers` = count including any `layer_start` in the same cycle. `err_layers` = (`out_layers` != LAYER_MAX), `err_timeout`=0. Go to DONE.
- RUN, k = TIMEOUT with no `net_done`: `out_data`=0, `out_cycles`=TIMEOUT, `out_layers`=current count, `err_timeout`=1, `err_layers`=0. Go to DONE. If `net_done` arrives at k=TIMEOUT, it takes priority and the inference completes normally.
- DONE: `out_valid`=1. Outputs are held stable until `out_valid & out_ready`, then go to IDLE.
- `start`, `in_ready`, `out_valid` and `busy` are decoded from the registered state (Moore outputs).
- Outside RUN, `layer_start` and `net_done` are ignored and do not modify any register.
- Reset: state IDLE, `start_input`/`out_data`/`out_layers`/`out_cycles`/errors = 0. After reset `in_ready`=1, `start`=0, `out_valid`=0, `busy`=0.
- Reset mid-operation aborts the inference. No result is produced, and the network must be reset alongside.

## Timing
- Accept edge at cycle 0 → `start`=1 in cycle 1 → RUN from cycle 2 (k=1).
- `net_done` at k → `out_valid`=1 at k+1. Back-to-back minimum: the next `in_ready` comes the cycle after the output handshake.
- Minimum throughput is 4 cycles per inference (accept, START, RUN k=1 done, DONE with `out_ready`=1).
- No combinational path from any input to any output.

## Test plan
- Nominal: LAYER_MAX=4, accept vector 0x1, four `layer_start` pulses at k=2,5,8,11, `net_done` at k=12 with `final_output`=0xABC, `out_ready`=1 → `out_valid` one cycle, `out_data`=0xABC, `out_layers`=4, `out_cycles`=12, both errors 0.
- Backpressure: hold `out_ready`=0 for 10 cycles → outputs stable, `in_ready`=0, second `in_valid` not accepted; release → IDLE, second vector accepted next cycle with `start` pulse.
- Timeout: TIMEOUT=16, no `net_done` → `out_valid` at k=17, `err_timeout`=1, `out_cycles`=16, `out_data`=0. Variant with `net_done` exactly at k=16 → normal completion, `err_timeout`=0.
- Layer mismatch: 3 `layer_start` pulses, then `net_done` (including one case where `layer_start` and `net_done` coincide, giving 4) → `err_layers`=1 for 3, `err_layers`=0 for the coincident case.
- Spurious pulses: `net_done`/`layer_start` in IDLE and DONE → no state change, DONE outputs unchanged.
- Reset mid-RUN at k=5 → next cycle IDLE, `start`=0, `out_valid`=0, all outputs 0, `in_ready`=1.

Source files
------------

// File: rtl/inference_scheduler.sv
// Front-end sequencer: accepts one input vector, pulses start to the layer controller,
// tracks layer launches and completion/timeout, and returns the result over valid/ready.
module inference_scheduler #(
  parameter int NUM_NEURON = 6,
  parameter int INPUT_SIZE = 9,
  parameter int LAYER_MAX  = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_SIZE   = 16,
  parameter int LW         = $clog2(LAYER_MAX) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_NEURON*INPUT_SIZE-1:0] in_data,
  output logic                           start,
  output logic [NUM_NEURON*INPUT_SIZE-1:0] start_input,
  input  logic                           layer_start,
  input  logic [NUM_NEURON*INPUT_SIZE-1:0] final_output,
  input  logic                           net_done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_NEURON*INPUT_SIZE-1:0] out_data,
  output logic [LW-1:0]                  out_layers,
  output logic [CNT_SIZE-1:0]            out_cycles,
  output logic                           err_timeout,
  output logic                           err_layers,
  output logic                           busy
);

  localparam int VW = NUM_NEURON * INPUT_SIZE;
  localparam logic [LW-1:0]       LAYER_SAT = '1;
  localparam logic [LW-1:0]       LAYER_TGT = LW'(LAYER_MAX);
  localparam logic [CNT_SIZE-1:0] TIMEOUT_C = CNT_SIZE'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [CNT_SIZE-1:0] cycle_r;
  logic [LW-1:0]       layer_r;
  logic [CNT_SIZE-1:0] k_s;
  logic [LW-1:0]       layer_next_s;
  logic                timeout_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: state_next_s = RUN;
      RUN: begin
        if (net_done || timeout_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Cycle index of the current RUN cycle and the layer count including this cycle's pulse
  always_comb begin
    k_s          = cycle_r + CNT_SIZE'(1);
    timeout_s    = (k_s == TIMEOUT_C);
    layer_next_s = layer_r;
    if (layer_start && (layer_r != LAYER_SAT)) begin
      layer_next_s = layer_r + LW'(1);
    end else begin
      layer_next_s = layer_r;
    end
  end

  // Input capture, run counters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      start_input <= {VW{1'b0}};
      cycle_r     <= {CNT_SIZE{1'b0}};
      layer_r     <= {LW{1'b0}};
      out_data    <= {VW{1'b0}};
      out_layers  <= {LW{1'b0}};
      out_cycles  <= {CNT_SIZE{1'b0}};
      err_timeout <= 1'b0;
      err_layers  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            start_input <= in_data;
          end
        end
        START: begin
          cycle_r <= {CNT_SIZE{1'b0}};
          layer_r <= {LW{1'b0}};
        end
        RUN: begin
          cycle_r <= k_s;
          layer_r <= layer_next_s;
          // A done pulse on the timeout cycle still counts as a normal completion
          if (net_done) begin
            out_data    <= final_output;
            out_cycles  <= k_s;
            out_layers  <= layer_next_s;
            err_layers  <= (layer_next_s != LAYER_TGT);
            err_timeout <= 1'b0;
          end else if (timeout_s) begin
            out_data    <= {VW{1'b0}};
            out_cycles  <= TIMEOUT_C;
            out_layers  <= layer_next_s;
            err_layers  <= 1'b0;
            err_timeout <= 1'b1;
          end
        end
        DONE: begin
          cycle_r <= cycle_r;
        end
        default: begin
          cycle_r <= cycle_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign start     = (state_r == START);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);

endmodule
